// File: rtl/fios_pkg.sv
// Shared types for the FIOS multiplier result path: limb width, limb type and
// the result-collector state encoding.
package fios_pkg;

  localparam int LIMB_W = 17;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} res_col_state_t;

  typedef logic [LIMB_W-1:0] limb_t;

endpackage

// File: rtl/fios_res_collector_limb_sub_borrow.sv
// One limb of the serial conditional subtraction: {bout, diff} = a - b - bin,
// evaluated as an 18-bit subtraction so the top bit is the borrow out.
module limb_sub_borrow
  import fios_pkg::*;
(
  input  limb_t a,
  input  limb_t b,
  input  logic  bin,
  output limb_t diff,
  output logic  bout
);

  logic [LIMB_W:0] wide;

  assign wide = {1'b0, a} - {1'b0, b} - {{LIMB_W{1'b0}}, bin};
  assign diff = wide[LIMB_W-1:0];
  assign bout = wide[LIMB_W];

endmodule

// File: rtl/fios_res_collector.sv
// Collects s serial result limbs (LS limb first) into a full word and hands it
// downstream over valid/ready; FIOS_RES_FINAL_SUB_EN adds the final R-p step.
module fios_res_collector
  import fios_pkg::*;
#(
  parameter int s      = 8,
  parameter int LIMB_W = 17
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [s*LIMB_W-1:0] p_i,
  input  logic                res_valid_i,
  input  logic [LIMB_W-1:0]   res_i,
  output logic [s*LIMB_W-1:0] result_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int W     = s * LIMB_W;
  localparam int CNT_W = (s > 1) ? $clog2(s) : 1;

  res_col_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LIMB_W-1:0] r_q [s];
  logic [LIMB_W-1:0] r_d [s];
  logic [W-1:0]      result_q, result_d;
  logic              err_q, err_d;
  logic [W-1:0]      rFull;
  logic [W-1:0]      finalVal;
  logic              limbFire;
  logic              lastLimb;

  assign limbFire = (state_q == COLLECT) && res_valid_i;
  assign lastLimb = limbFire && (cnt_q == CNT_W'(s - 1));

  // Complete R as it will look once the limb on res_i is written (the last one).
  always_comb begin
    rFull = '0;
    for (int i = 0; i < s; i++) begin
      rFull[i*LIMB_W +: LIMB_W] = (i == s - 1) ? res_i : r_q[i];
    end
  end

`ifdef FIOS_RES_FINAL_SUB_EN
  logic [LIMB_W-1:0] p_q [s];
  logic [LIMB_W-1:0] p_d [s];
  logic [LIMB_W-1:0] d_q [s];
  logic [LIMB_W-1:0] d_d [s];
  logic              borrow_q, borrow_d;
  logic [LIMB_W-1:0] subDiff;
  logic              subBout;
  logic              startAcc;
  logic [W-1:0]      dFull;

  assign startAcc = start_i && ((state_q == IDLE) || ((state_q == DONE) && ready_i));

  limb_sub_borrow u_limb_sub_borrow (
    .a   (res_i),
    .b   (p_q[cnt_q]),
    .bin (borrow_q),
    .diff(subDiff),
    .bout(subBout)
  );

  always_comb begin
    p_d      = p_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    if (startAcc) begin
      for (int i = 0; i < s; i++) p_d[i] = p_i[i*LIMB_W +: LIMB_W];
      borrow_d = 1'b0;
    end else if (limbFire) begin
      d_d[cnt_q] = subDiff;
      borrow_d   = subBout;
    end
  end

  // A borrow out of the top limb means R < p, so the unreduced R is kept.
  always_comb begin
    dFull = '0;
    for (int i = 0; i < s; i++) begin
      dFull[i*LIMB_W +: LIMB_W] = (i == s - 1) ? subDiff : d_q[i];
    end
    finalVal = subBout ? rFull : dFull;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < s; i++) begin
        p_q[i] <= '0;
        d_q[i] <= '0;
      end
      borrow_q <= 1'b0;
    end else begin
      p_q      <= p_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
    end
  end
`else
  logic unusedP;

  assign unusedP  = ^p_i;
  assign finalVal = rFull;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (res_valid_i) err_d = 1'b1;
        if (start_i) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        if (start_i) err_d = 1'b1;
        if (res_valid_i) begin
          r_d[cnt_q] = res_i;
          if (lastLimb) begin
            cnt_d    = '0;
            state_d  = DONE;
            result_d = finalVal;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (res_valid_i) err_d = 1'b1;
        if (ready_i) begin
          state_d = start_i ? COLLECT : IDLE;
          cnt_d   = '0;
        end else if (start_i) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      for (int i = 0; i < s; i++) r_q[i] <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign result_o = result_q;
  assign valid_o  = (state_q == DONE);
  assign busy_o   = (state_q != IDLE);
  assign err_o    = err_q;

endmodule

// File: doc/fios_res_collector.md
Name: fios_res_collector

Overview:
- Receiving end of the FIOS multiplier result stream.
- Captures the s serial 17-bit RES_o limbs, least significant limb first, and reassembles them into a full s*17-bit word.
- Applies the final Montgomery conditional subtraction (R >= p ? R-p : R) limb-serially while collecting.
- Presents the reduced result to the downstream consumer with a valid/ready handshake.

Parameters:
- s, 8, number of 17-bit limbs per operand; must match the multiplier's s.
- LIMB_W, 17, limb width in bits; fixed by the DSP datapath.
- localparam W = s*LIMB_W, full operand width.
- localparam CNT_W = $clog2(s) (minimum 1), limb index counter width.

Ports:
- clock_i  input  1  single clock for the block.
- reset_i  input  1  asynchronous, active-high reset.
- start_i  input  1  one-cycle pulse; a multiplication has been launched; latches p_i.
- p_i  input  W  full modulus; sampled only on an accepted start_i.
- res_valid_i  input  1  the limb on res_i is valid this cycle.
- res_i  input  LIMB_W  result limb from the multiplier's RES_o.
- result_o  output  W  reduced result; stable while valid_o is high.
- valid_o  output  1  result_o holds a complete result.
- ready_i  input  1  downstream accepts result_o when valid_o && ready_i.
- busy_o  output  1  high in COLLECT or DONE.
- err_o  output  1  sticky protocol error; cleared only by reset.

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, cnt=0, borrow=0, R/D/p registers=0, result_o=0, valid_o=0, busy_o=0, err_o=0.
- FSM states are IDLE, COLLECT and DONE.
- IDLE:
  - start_i -> COLLECT; p_reg<=p_i, cnt<=0, borrow<=0.
- COLLECT, on res_valid_i:
  - R[cnt]<=res_i.
  - {b',D[cnt]} <= res_i - p_reg[cnt] - borrow, computed as an 18-bit subtraction; b' is the borrow out; borrow<=b'.
  - cnt<=cnt+1.
  - If cnt==s-1: go to DONE; cnt wraps to 0.
- COLLECT without res_valid_i: hold all state. Gaps between limbs are legal.
- DONE:
  - valid_o=1.
  - result_o = final borrow ? R : D, registered on the COLLECT->DONE edge. Latency is 1 cycle from the last limb to valid_o.
  - result_o is held until valid_o && ready_i, then -> IDLE.
- Simultaneous handshake and start_i in DONE: the start is accepted. Go straight to COLLECT with the new p_i; valid_o drops the next cycle.
- Error conditions (each sets err_o; state is otherwise unaffected):
  - start_i in COLLECT: ignored.
  - start_i in DONE without a handshake: ignored.
  - res_valid_i in IDLE: limb dropped.
  - res_valid_i in DONE: limb dropped.
- Input contract: R < 2p. No carry limb beyond s limbs is expected.
- Reset asserted mid-COLLECT discards the partial result. No valid_o follows.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: FIOS_RES_FINAL_SUB_EN.
- Defined: conditional subtraction as described. The D registers and borrow logic are present.
- Undefined: D and borrow are removed, result_o = R (raw, in [0,2p)), and p_i is ignored. Latency and handshake are unchanged.

Decomposition:
- Shared package fios_pkg:
  - LIMB_W constant.
  - typedef enum logic [1:0] {IDLE, COLLECT, DONE} res_col_state_t.
  - typedef logic [LIMB_W-1:0] limb_t.
- One natural sub-module: limb_sub_borrow, combinational. Inputs are a, b (limb_t) and bin. Outputs are diff (limb_t) and bout.

Test Plan (s=2, limbs listed {hi,lo} in hex; p={0x00001,0x00005}):
- Reduction path: start, p=above; limbs lo=0x00007, hi=0x00001. Expect valid_o one cycle after the hi limb, result_o={0x00000,0x00002}.
- No-reduction path: limbs lo=0x00003, hi=0x00001. Expect result_o={0x00001,0x00003}, since R<p.
- Borrow ripple: limbs lo=0x00004, hi=0x00002. Expect result_o={0x00000,0x1FFFF}, since R-p=0x1FFFF.
- Backpressure and back-to-back:
  - Hold ready_i=0 for 5 cycles: result_o stable and valid_o high throughout.
  - Then pulse ready_i together with start_i: new collection begins and valid_o is low the next cycle.
- Errors and reset:
  - res_valid_i in IDLE: err_o=1, no state change.
  - reset_i asserted after 1 limb: all outputs 0 immediately.
  - Restart after reset: normal result.
- Macro off: the reduction-path stimulus yields result_o={0x00001,0x00007}.
